// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Sequencer for a dual 4:1 mux. Walks the four select codes with
//               both halves enabled, samples y1/y2 after a settle delay and
//               assembles an 8-bit word (bit k = mux input in_k) with a
//               one-cycle valid strobe. One-shot or continuous scanning.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       y1,
    input  logic       y2,
    output logic       selb,
    output logic       sela,
    output logic       e1,
    output logic       e2,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy
);

    // Last settle count before sampling; unused when the settle phase is bypassed.
    localparam logic [3:0] C_LAST   = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
    localparam logic       C_BYPASS = (SETTLE_CYC == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    state_t     r_state,  w_state;
    logic [1:0] r_idx,    w_idx;
    logic [3:0] r_cnt,    w_cnt;
    logic [7:0] r_shadow, w_shadow;
    logic [7:0] r_data,   w_data;
    logic       r_valid,  w_valid;
    logic       r_busy,   w_busy;
    logic       r_en,     w_en;
    logic [1:0] r_sel,    w_sel;

    // State entered at the start of every step: settle first unless bypassed.
    state_t w_step_state;
    assign w_step_state = C_BYPASS ? S_SAMPLE : S_SETTLE;

    // Register all state and the registered mux controls / outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 8'h00;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_en     <= 1'b0;
            r_sel    <= 2'b00;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_cnt    <= w_cnt;
            r_shadow <= w_shadow;
            r_data   <= w_data;
            r_valid  <= w_valid;
            r_busy   <= w_busy;
            r_en     <= w_en;
            r_sel    <= w_sel;
        end
    end

    // Next-state logic: settle on each select code, sample both halves, assemble word.
    always_comb begin
        w_state  = r_state;
        w_idx    = r_idx;
        w_cnt    = r_cnt;
        w_shadow = r_shadow;
        w_data   = r_data;
        w_valid  = 1'b0;
        w_busy   = r_busy;
        w_en     = r_en;
        w_sel    = r_sel;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_idx   = 2'd0;
                    w_cnt   = 4'd0;
                    w_en    = 1'b1;
                    w_sel   = 2'b00;
                    w_busy  = 1'b1;
                    w_state = w_step_state;
                end
            end
            S_SETTLE: begin
                w_cnt = r_cnt + 4'd1;
                if (r_cnt == C_LAST) begin
                    w_state = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_shadow[r_idx]          = y1;
                w_shadow[{1'b1, r_idx}]  = y2;
                w_cnt                    = 4'd0;
                if (r_idx != 2'd3) begin
                    w_idx   = r_idx + 2'd1;
                    w_sel   = r_idx + 2'd1;
                    w_state = w_step_state;
                end else begin
                    // Final step: the live y1/y2 bits go straight into the word.
                    w_data  = {y2, r_shadow[6:4], y1, r_shadow[2:0]};
                    w_valid = 1'b1;
                    w_idx   = 2'd0;
                    w_sel   = 2'b00;
                    if (cont) begin
                        w_state = w_step_state;
                    end else begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_en    = 1'b0;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign selb     = r_sel[1];
    assign sela     = r_sel[0];
    assign e1       = r_en;
    assign e2       = r_en;
    assign data_out = r_data;
    assign valid    = r_valid;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl. Two instances
//               (settle 2 and settle 0), each behind a combinational dual 4:1
//               mux model, compared every cycle against a time-based scan model
//               plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int P_A = 3;   // settle 2 -> 3 cycles per select code
    localparam int P_B = 1;   // settle 0 -> 1 cycle per select code

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0;
    logic cont_b = 1'b0;
    logic [7:0] in_a = 8'h00, in_b = 8'h00;

    logic selb_a, sela_a, e1_a, e2_a, valid_a, busy_a;
    logic selb_b, sela_b, e1_b, e2_b, valid_b, busy_b;
    logic [7:0] data_a, data_b;
    logic y1_a, y2_a, y1_b, y2_b;

    int  n_pass  = 0;
    int  n_total = 0;
    logic armed  = 1'b0;

    always #5 clk = ~clk;

    // Gate-level dual 4:1 mux: a disabled half drives 0.
    assign y1_a = e1_a & in_a[{selb_a, sela_a}];
    assign y2_a = e2_a & in_a[{1'b1, selb_a, sela_a}];
    assign y1_b = e1_b & in_b[{selb_b, sela_b}];
    assign y2_b = e2_b & in_b[{1'b1, selb_b, sela_b}];

    mux_scan_ctrl #(.SETTLE_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cont(cont_a), .y1(y1_a), .y2(y2_a),
        .selb(selb_a), .sela(sela_a), .e1(e1_a), .e2(e2_a),
        .data_out(data_a), .valid(valid_a), .busy(busy_a));

    mux_scan_ctrl #(.SETTLE_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .y1(y1_b), .y2(y2_b),
        .selb(selb_b), .sela(sela_b), .e1(e1_b), .e2(e2_b),
        .data_out(data_b), .valid(valid_b), .busy(busy_b));

    // Scan model: t counts cycles since the scan began; every p-th cycle closes
    // a sample of in[k] and in[k+4] straight from the input vector.
    typedef struct packed {
        logic       busy;
        logic [7:0] t;
        logic [7:0] word;
        logic [7:0] data;
        logic       valid;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    function automatic mdl_t mstep(mdl_t m, logic r, logic s, logic c, logic [7:0] iv, int p);
        mdl_t n;
        int   tt;
        int   k;
        n       = m;
        n.valid = 1'b0;
        tt      = int'(m.t);
        if (r) begin
            n = '0;
        end else if (!m.busy) begin
            if (s) begin
                n.busy = 1'b1;
                n.t    = 8'd0;
            end
        end else begin
            if (tt % p == p - 1) begin
                k = tt / p;
                n.word[k]     = iv[k];
                n.word[k + 4] = iv[k + 4];
            end
            if (tt == 4 * p - 1) begin
                n.data  = n.word;
                n.valid = 1'b1;
                n.t     = 8'd0;
                n.busy  = c;
            end else begin
                n.t = 8'(tt + 1);
            end
        end
        return n;
    endfunction

    // Expected {selb,sela,e1,e2,busy,valid,data_out} for the current cycle.
    function automatic logic [13:0] mexp(mdl_t m, int p);
        logic [1:0] sel;
        sel = m.busy ? 2'(int'(m.t) / p) : 2'b00;
        return {sel, m.busy, m.busy, m.busy, m.valid, m.data};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Advance both models on the same edges the DUTs see.
    always @(posedge clk) begin
        ma <= mstep(ma, rst, start_a, cont_a, in_a, P_A);
        mb <= mstep(mb, rst, start_b, cont_b, in_b, P_B);
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("cycle_a", {18'd0, selb_a, sela_a, e1_a, e2_a, busy_a, valid_a, data_a},
                {18'd0, mexp(ma, P_A)});
            chk("cycle_b", {18'd0, selb_b, sela_b, e1_b, e2_b, busy_b, valid_b, data_b},
                {18'd0, mexp(mb, P_B)});
        end
    end

    // Pulse start across exactly one rising edge; returns in the first cycle after it.
    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_valid_a(output int lat);
        lat = 0;
        while (!valid_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_valid_a(input int cycles, output int nv);
        nv = 0;
        repeat (cycles) begin
            if (valid_a) nv++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int lat2;
        int nv;

        // Reset with start held high: nothing may begin.
        rst     = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clk);
        #1 armed = 1'b1;
        @(negedge clk);
        chk("reset_data", {24'd0, data_a}, 32'h00);
        chk("reset_ctrl", {26'd0, selb_a, sela_a, e1_a, e2_a, busy_a, valid_a}, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy_a}, 32'd0);

        // One-shot scan of 8'hA6.
        in_a = 8'hA6;
        pulse_a();
        wait_valid_a(lat);
        chk("oneshot_latency", lat, 32'd12);
        chk("oneshot_data", {24'd0, data_a}, 32'hA6);
        @(negedge clk);
        chk("oneshot_valid_width", {31'd0, valid_a}, 32'd0);
        chk("oneshot_idle", {29'd0, busy_a, e1_a, e2_a}, 32'd0);

        // Start pulses while busy are ignored.
        in_a = 8'h5A;
        pulse_a();
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        count_valid_a(30, nv);
        chk("busy_start_valids", nv, 32'd1);
        chk("busy_start_data", {24'd0, data_a}, 32'h5A);

        // Reset mid-scan discards everything.
        pulse_a();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_data", {24'd0, data_a}, 32'h00);
        chk("midreset_busy", {30'd0, busy_a, valid_a}, 32'd0);
        count_valid_a(20, nv);
        chk("midreset_no_valid", nv, 32'd0);

        // Continuous mode with the inputs changing during step 2.
        in_a   = 8'h3C;
        cont_a = 1'b1;
        pulse_a();
        repeat (7) @(negedge clk);
        in_a = 8'hC3;
        wait_valid_a(lat);
        chk("cont_first_latency", lat + 7, 32'd12);
        chk("cont_first_word", {24'd0, data_a}, 32'hF0);
        @(negedge clk);
        wait_valid_a(lat2);
        chk("cont_period", lat2 + 1, 32'd12);
        chk("cont_second_word", {24'd0, data_a}, 32'hC3);
        cont_a = 1'b0;
        @(negedge clk);
        count_valid_a(40, nv);
        chk("cont_drop_valids", nv, 32'd1);
        chk("cont_drop_idle", {31'd0, busy_a}, 32'd0);

        // Settle-0 instance: one cycle per select code.
        in_b    = 8'hFF;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 0;
        while (!valid_b && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("settle0_latency", lat, 32'd4);
        chk("settle0_data", {24'd0, data_b}, 32'hFF);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
